async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, pointer width; depth = 2**ADDR_WIDTH (16 by default).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_w_en  input  1  write request; sampled on rising i_clk.
REQ-007 i_wdata  input  DATA_WIDTH  write data; captured with i_w_en.
REQ-008 i_r_en  input  1  read request (pop); sampled on rising i_clk.
REQ-009 o_rdata  output  DATA_WIDTH  current head-of-queue word (first-word-fall-through).
REQ-010 o_buf_full  output  1  high when the FIFO holds DEPTH words.
REQ-011 o_buf_empty  output  1  high when the FIFO holds 0 words.

Function
REQ-012 Storage: DEPTH x DATA_WIDTH array; write pointer and read pointer, each ADDR_WIDTH+1 bits (extra wrap bit).
REQ-013 Write accepted when i_w_en=1 and o_buf_full=0 at the rising edge: mem[wptr]<=i_wdata, wptr<=wptr+1.
REQ-014 Read accepted when i_r_en=1 and o_buf_empty=0 at the rising edge: rptr<=rptr+1.
REQ-015 Write while full is ignored: no memory change, no pointer change, data lost.
REQ-016 Read while empty is ignored: no pointer change.
REQ-017 Simultaneous write and read in one cycle: both accepted per their own conditions, evaluated on pre-edge flags; occupancy unchanged when both accepted.
REQ-018 o_buf_empty SHALL equal (wptr == rptr), full width including wrap bit.
REQ-019 o_buf_full SHALL equal (wptr[MSB] != rptr[MSB]) and (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]).
REQ-020 Flags reflect pointer state immediately after each edge (zero-cycle flag latency after the updating edge).
REQ-021 o_rdata SHALL combinationally present mem[rptr[ADDR_WIDTH-1:0]] when not empty; first written word visible the cycle after its write edge without a read.
REQ-022 o_rdata SHALL be all zeros while o_buf_empty=1.
REQ-023 Pointers wrap modulo 2**(ADDR_WIDTH+1); address bits wrap modulo DEPTH; ordering strictly first-in first-out across wrap.
REQ-024 Capacity exactly DEPTH words; no lookahead/almost flags.

Reset
REQ-025 i_rst_n=0 SHALL immediately (asynchronously) clear wptr and rptr to 0.
REQ-026 During/after reset: o_buf_empty=1, o_buf_full=0, o_rdata=0.
REQ-027 Memory contents need not be cleared; they are unobservable after reset because FIFO is empty.
REQ-028 Reset asserted mid-operation discards all stored data; write/read requests during reset are ignored.
REQ-029 Deassertion of reset is synchronous-safe: first accepted operation occurs on the first rising i_clk with i_rst_n=1.

Verification
REQ-030 Reset then idle -> o_buf_empty=1, o_buf_full=0, o_rdata=0x00.
REQ-031 Push 1 -> next cycle o_buf_empty=0, o_rdata=1; pop -> o_buf_empty=1, o_rdata=0.
REQ-032 Push 1..16 -> o_buf_full=1 after 16th write; push 17 ignored; 16 pops return 1..16 in order, then o_buf_empty=1.
REQ-033 Push 1..9, pop (returns 1), push 10..16, pop (2), push 17, pop (3), push 18 -> no data lost, subsequent pops return 4..18 in order across pointer wrap.
REQ-034 With 5 words stored, assert i_w_en and i_r_en same cycle for 20 cycles -> occupancy stays 5, output order preserved, flags unchanged.
REQ-035 Pop on empty -> no pointer change, o_buf_empty stays 1; assert i_rst_n=0 with 8 words stored -> immediately empty=1, full=0, o_rdata=0.

Source files
------------

// File: rtl/async_fifo.sv
// Synchronous first-word-fall-through FIFO, DEPTH = 2**ADDR_WIDTH words, on a single clock.
// Latency: a word written on one edge is visible on o_rdata right after that edge; the flags update on the same edge.
// Backpressure: writes while full and reads while empty are dropped; i_w_en and i_r_en are both gated by the flags as they were before the edge.
module async_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_w_en,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_r_en,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_buf_full,
    output logic                  o_buf_empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // The extra pointer MSB tells full (laps differ) apart from empty (laps match).
    assign o_buf_empty = (wptr == rptr);
    assign o_buf_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                         (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

    assign wr_acc = i_w_en && !o_buf_full;
    assign rd_acc = i_r_en && !o_buf_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
        end
    end

    // Storage is not reset; its contents are unobservable while empty.
    always_ff @(posedge i_clk) begin
        if (wr_acc) mem[wptr[ADDR_WIDTH-1:0]] <= i_wdata;
    end

    assign o_rdata = o_buf_empty ? '0 : mem[rptr[ADDR_WIDTH-1:0]];

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo using the default 8-bit x 16-word configuration.
module tb_async_fifo;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_w_en;
    logic [7:0] i_wdata;
    logic       i_r_en;
    logic [7:0] o_rdata;
    logic       o_buf_full;
    logic       o_buf_empty;

    int checks;
    int errors;

    async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_w_en     (i_w_en),
        .i_wdata    (i_wdata),
        .i_r_en     (i_r_en),
        .o_rdata    (o_rdata),
        .o_buf_full (o_buf_full),
        .o_buf_empty(o_buf_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given requests; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        i_w_en  = w;
        i_wdata = d;
        i_r_en  = r;
        @(posedge i_clk);
        #1;
        i_w_en = 1'b0;
        i_r_en = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_rst_n = 1'b0;
        i_w_en  = 1'b0;
        i_r_en  = 1'b0;
        i_wdata = 8'h00;

        // Reset, then idle
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("rst_empty", o_buf_empty, 1);
        chk("rst_full", o_buf_full, 0);
        chk("rst_rdata", o_rdata, 8'h00);

        // Single push and pop
        push(8'h01);
        chk("p1_empty", o_buf_empty, 0);
        chk("p1_rdata", o_rdata, 8'h01);
        chk("p1_full", o_buf_full, 0);
        pop();
        chk("pop1_empty", o_buf_empty, 1);
        chk("pop1_rdata", o_rdata, 8'h00);

        // Fill to capacity, overflow, then drain
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            if (i == 15) chk("fill15_full", o_buf_full, 0);
        end
        chk("fill16_full", o_buf_full, 1);
        chk("fill16_empty", o_buf_empty, 0);
        push(8'd17);
        chk("ovf_full", o_buf_full, 1);
        chk("ovf_head", o_rdata, 8'd1);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain_%0d", i), o_rdata, i);
            pop();
            if (i == 1) chk("drain_full_clr", o_buf_full, 0);
        end
        chk("drain_empty", o_buf_empty, 1);
        chk("drain_rdata0", o_rdata, 8'h00);

        // Interleaved push/pop across the pointer wrap
        for (int i = 1; i <= 9; i++) push(8'(i));
        chk("wrap_pop1", o_rdata, 8'd1);
        pop();
        for (int i = 10; i <= 16; i++) push(8'(i));
        chk("wrap_pop2", o_rdata, 8'd2);
        pop();
        push(8'd17);
        chk("wrap_pop3", o_rdata, 8'd3);
        pop();
        push(8'd18);
        chk("wrap_full15", o_buf_full, 0);
        for (int i = 4; i <= 18; i++) begin
            chk($sformatf("wrap_%0d", i), o_rdata, i);
            pop();
        end
        chk("wrap_empty", o_buf_empty, 1);

        // Simultaneous read and write with 5 words stored
        for (int i = 0; i < 5; i++) push(8'(100 + i));
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("rw_head_%0d", k), o_rdata, 100 + k);
            cyc(1'b1, 8'(105 + k), 1'b1);
            chk($sformatf("rw_empty_%0d", k), o_buf_empty, 0);
            chk($sformatf("rw_full_%0d", k), o_buf_full, 0);
        end
        for (int i = 120; i <= 124; i++) begin
            chk($sformatf("rw_tail_%0d", i), o_rdata, i);
            pop();
        end
        chk("rw_occ_empty", o_buf_empty, 1);

        // Read+write while empty: only the write lands
        cyc(1'b1, 8'hA5, 1'b1);
        chk("rwe_empty", o_buf_empty, 0);
        chk("rwe_rdata", o_rdata, 8'hA5);
        pop();
        chk("rwe_drain", o_buf_empty, 1);

        // Read+write while full: only the read lands
        for (int i = 0; i < 16; i++) push(8'(200 + i));
        cyc(1'b1, 8'h77, 1'b1);
        chk("rwf_full", o_buf_full, 0);
        chk("rwf_head", o_rdata, 8'd201);
        for (int i = 201; i <= 215; i++) begin
            chk($sformatf("rwf_%0d", i), o_rdata, i);
            pop();
        end
        chk("rwf_empty", o_buf_empty, 1);

        // Pop on empty leaves pointers alone
        pop();
        chk("pope_empty", o_buf_empty, 1);
        chk("pope_rdata", o_rdata, 8'h00);
        push(8'h55);
        chk("pope_push", o_rdata, 8'h55);
        pop();
        chk("pope_drain", o_buf_empty, 1);

        // Asynchronous reset with 8 words stored
        for (int i = 0; i < 8; i++) push(8'(16 + i));
        chk("pre_rst_head", o_rdata, 8'd16);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_empty", o_buf_empty, 1);
        chk("arst_full", o_buf_full, 0);
        chk("arst_rdata", o_rdata, 8'h00);
        cyc(1'b1, 8'h99, 1'b0);
        chk("rst_wr_ignored", o_buf_empty, 1);
        i_rst_n = 1'b1;
        push(8'h3C);
        chk("post_rst_rdata", o_rdata, 8'h3C);
        chk("post_rst_empty", o_buf_empty, 0);
        pop();
        chk("post_rst_drain", o_buf_empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
